// File: rtl/pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs
//
// Pipeline stage register with valid/ready handshake between two CPU pipeline
// stages. Payload fields are concatenated by the instantiating stage into one
// DW-bit bus. Stalls propagate as backpressure only.
//
// Parameters
//   DW          payload width
//   SBW         sideband width
//   SKID        1: 2-entry skid buffer, up_ready driven from state only
//               0: single entry, up_ready = !dn_valid || dn_ready
//   CLR_PAYLOAD 1: zero the payload register whenever its entry goes invalid
//
// Ports
//   clk        rising-edge clock
//   cpurst     asynchronous active-high reset
//   up_valid   upstream payload present      up_ready  stage can accept
//   up_data    upstream payload
//   dn_valid   payload presented downstream  dn_ready  downstream accepts
//   dn_data    payload to downstream (main register)
//   flush      drop all held entries
//   sb_in      sideband in                   sb_out    sideband, registered
//                                                      every cycle
//   occupancy  number of valid entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_hs #(
    parameter int DW          = 128,
    parameter int SBW         = 32,
    parameter int SKID        = 1,
    parameter int CLR_PAYLOAD = 1
) (
    input  logic           clk,
    input  logic           cpurst,
    input  logic           up_valid,
    output logic           up_ready,
    input  logic [DW-1:0]  up_data,
    output logic           dn_valid,
    input  logic           dn_ready,
    output logic [DW-1:0]  dn_data,
    input  logic           flush,
    input  logic [SBW-1:0] sb_in,
    output logic [SBW-1:0] sb_out,
    output logic [1:0]     occupancy
);

    // State encoding equals the entry count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_main;
    logic [DW-1:0]   r_skid;
    logic [DW-1:0]   w_main_nxt;
    logic [DW-1:0]   w_skid_nxt;
    logic [SBW-1:0]  r_sb;
    logic            w_acc;
    logic            w_deq;

    // Value written into a register whose entry becomes invalid.
    function automatic logic [DW-1:0] f_inval(input logic [DW-1:0] d);
        if (CLR_PAYLOAD != 0) begin
            return '0;
        end
        return d;
    endfunction

    assign dn_valid  = (r_state != ST_EMPTY);
    assign dn_data   = r_main;
    assign sb_out    = r_sb;
    assign occupancy = r_state;

    // With the skid buffer, up_ready depends only on registered state, which
    // breaks the dn_ready -> up_ready combinational path.
    assign up_ready = (SKID != 0) ? (r_state != ST_TWO) : (!dn_valid || dn_ready);

    assign w_acc = up_valid && up_ready;
    assign w_deq = dn_valid && dn_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        if (flush) begin
            // Accept in this cycle is discarded; a deq in this cycle completes.
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = f_inval(r_main);
            w_skid_nxt  = f_inval(r_skid);
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_main_nxt  = up_data;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_deq) begin
                        w_main_nxt = up_data;
                    end else if (w_acc) begin
                        // Only reachable with SKID=1: without the skid buffer
                        // an accept in ONE always coincides with a deq.
                        if (SKID != 0) begin
                            w_skid_nxt  = up_data;
                            w_state_nxt = ST_TWO;
                        end else begin
                            w_main_nxt = up_data;
                        end
                    end else if (w_deq) begin
                        w_main_nxt  = f_inval(r_main);
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_deq) begin
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = f_inval(r_skid);
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = '0;
                    w_skid_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_sb    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            r_sb    <= sb_in;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;

    localparam int DW  = 16;
    localparam int SBW = 16;

    logic           clk;
    logic           cpurst;
    logic           flush;
    logic [SBW-1:0] sb_in;

    // Instance A: SKID=1
    logic           a_uv, a_ur, a_dv, a_dr;
    logic [DW-1:0]  a_ud, a_dd;
    logic [SBW-1:0] a_sb;
    logic [1:0]     a_occ;

    // Instance B: SKID=0
    logic           b_uv, b_ur, b_dv, b_dr;
    logic [DW-1:0]  b_ud, b_dd;
    logic [SBW-1:0] b_sb;
    logic [1:0]     b_occ;

    int n_checks;
    int n_errors;
    int n_del;

    pipe_stage_hs #(.DW(DW), .SBW(SBW), .SKID(1), .CLR_PAYLOAD(1)) u_a (
        .clk       (clk),
        .cpurst    (cpurst),
        .up_valid  (a_uv),
        .up_ready  (a_ur),
        .up_data   (a_ud),
        .dn_valid  (a_dv),
        .dn_ready  (a_dr),
        .dn_data   (a_dd),
        .flush     (flush),
        .sb_in     (sb_in),
        .sb_out    (a_sb),
        .occupancy (a_occ)
    );

    pipe_stage_hs #(.DW(DW), .SBW(SBW), .SKID(0), .CLR_PAYLOAD(1)) u_b (
        .clk       (clk),
        .cpurst    (cpurst),
        .up_valid  (b_uv),
        .up_ready  (b_ur),
        .up_data   (b_ud),
        .dn_valid  (b_dv),
        .dn_ready  (b_dr),
        .dn_data   (b_dd),
        .flush     (flush),
        .sb_in     (sb_in),
        .sb_out    (b_sb),
        .occupancy (b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_del    = 0;
        cpurst = 1'b1;
        flush  = 1'b0;
        sb_in  = '0;
        a_uv = 1'b0; a_ud = '0; a_dr = 1'b1;
        b_uv = 1'b0; b_ud = '0; b_dr = 1'b1;

        // Reset values
        tick();
        tick();
        chk("rst_a_dv",  a_dv,  0);
        chk("rst_a_dd",  a_dd,  0);
        chk("rst_a_occ", a_occ, 0);
        chk("rst_a_ur",  a_ur,  1);
        chk("rst_a_sb",  a_sb,  0);
        chk("rst_b_dv",  b_dv,  0);
        chk("rst_b_ur",  b_ur,  1);
        chk("rst_b_occ", b_occ, 0);
        cpurst = 1'b0;
        tick();
        chk("post_rst_a_ur", a_ur, 1);

        // Back-to-back stream 1..8 on both instances
        a_uv = 1'b1; a_ud = 16'h1;
        b_uv = 1'b1; b_ud = 16'h1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("strm_a_dv",  a_dv,  1);
            chk("strm_a_dd",  a_dd,  i);
            chk("strm_a_occ", a_occ, 1);
            chk("strm_b_dd",  b_dd,  i);
            chk("strm_b_occ", b_occ, 1);
            if (i < 8) begin
                a_ud = 16'(i + 1);
                b_ud = 16'(i + 1);
            end else begin
                a_uv = 1'b0;
                b_uv = 1'b0;
            end
        end
        tick();
        chk("strm_end_a_dv",  a_dv,  0);
        chk("strm_end_a_dd",  a_dd,  0);
        chk("strm_end_a_occ", a_occ, 0);
        chk("strm_end_b_dv",  b_dv,  0);

        // Skid: A, B, C with dn_ready low from the second cycle
        a_uv = 1'b1; a_ud = 16'hA; a_dr = 1'b1;
        tick();
        a_dr = 1'b0; a_ud = 16'hB;
        tick();
        a_ud = 16'hC;
        #1;
        chk("skid_dd",  a_dd,  16'hA);
        chk("skid_occ", a_occ, 2);
        chk("skid_ur",  a_ur,  0);
        chk("skid_dv",  a_dv,  1);
        tick();
        chk("skid_hold_dd",  a_dd,  16'hA);
        chk("skid_hold_occ", a_occ, 2);
        chk("skid_hold_ur",  a_ur,  0);
        a_dr = 1'b1;
        tick();
        chk("skid_rel_dd",  a_dd,  16'hB);
        chk("skid_rel_occ", a_occ, 1);
        chk("skid_rel_ur",  a_ur,  1);
        tick();
        chk("skid_c_dd",  a_dd,  16'hC);
        chk("skid_c_occ", a_occ, 1);
        a_uv = 1'b0;
        tick();
        chk("skid_drain_dv",  a_dv,  0);
        chk("skid_drain_occ", a_occ, 0);

        // Flush while in TWO with 0xD presented
        a_uv = 1'b1; a_ud = 16'h11; a_dr = 1'b0;
        tick();
        a_ud = 16'h12;
        tick();
        chk("fl2_pre_occ", a_occ, 2);
        flush = 1'b1; a_ud = 16'hD;
        tick();
        flush = 1'b0; a_uv = 1'b0; a_dr = 1'b1;
        chk("fl2_dv",  a_dv,  0);
        chk("fl2_dd",  a_dd,  0);
        chk("fl2_occ", a_occ, 0);
        chk("fl2_ur",  a_ur,  1);
        tick();
        chk("fl2_after1_dv", a_dv, 0);
        tick();
        chk("fl2_after2_dv", a_dv, 0);

        // Flush in ONE with an upstream handshake in the same cycle
        a_uv = 1'b1; a_ud = 16'h33; a_dr = 1'b0;
        tick();
        chk("fl1_pre_dd", a_dd, 16'h33);
        flush = 1'b1; a_ud = 16'hE; a_dr = 1'b1;
        tick();
        flush = 1'b0; a_uv = 1'b0;
        chk("fl1_dv",  a_dv,  0);
        chk("fl1_dd",  a_dd,  0);
        chk("fl1_occ", a_occ, 0);
        tick();
        chk("fl1_after_dv", a_dv, 0);

        // SKID=0: dn_ready toggling, up_ready follows it combinationally
        b_uv = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k <= 9) begin
                b_dr = (k % 2 == 0);
                b_ud = 16'(16'h20 + (k + 1) / 2);
            end else begin
                b_uv = 1'b0;
                b_dr = 1'b1;
            end
            #1;
            if (k <= 9) begin
                chk("tog_ur", b_ur, (k % 2 == 0) ? 1 : 0);
                if (k >= 1) chk("tog_dd", b_dd, 16'h20 + (k - 1) / 2);
            end
            if (b_dv && b_dr) begin
                chk("tog_deq", b_dd, 16'h20 + n_del);
                n_del++;
            end
            tick();
        end
        chk("tog_count", n_del, 5);
        chk("tog_end_dv", b_dv, 0);

        // Sideband follows sb_in while A is stalled full
        a_uv = 1'b1; a_ud = 16'h44; a_dr = 1'b0;
        tick();
        a_ud = 16'h45;
        tick();
        for (int k = 0; k < 5; k++) begin
            sb_in = 16'(16'h100 + k);
            tick();
            chk("sb_a",     a_sb,  16'h100 + k);
            chk("sb_b",     b_sb,  16'h100 + k);
            chk("sb_occ",   a_occ, 2);
            chk("sb_dd",    a_dd,  16'h44);
        end

        // Asynchronous reset between clock edges
        sb_in = 16'h155;
        tick();
        chk("arst_pre_sb", a_sb, 16'h155);
        #2;
        cpurst = 1'b1;
        #1;
        chk("arst_a_dv",  a_dv,  0);
        chk("arst_a_dd",  a_dd,  0);
        chk("arst_a_occ", a_occ, 0);
        chk("arst_a_ur",  a_ur,  1);
        chk("arst_a_sb",  a_sb,  0);
        chk("arst_b_sb",  b_sb,  0);
        a_uv = 1'b0; a_dr = 1'b1;
        tick();
        cpurst = 1'b0;
        tick();
        chk("arst_rel_occ", a_occ, 0);
        chk("arst_rel_ur",  a_ur,  1);
        chk("arst_rel_sb",  a_sb,  16'h155);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
